// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream side,
// downstream side, flush and the status counters.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;
  logic [15:0]       stall_cnt;

  // Environment side: produces upstream entries and downstream ready.
  modport master (
    output flush, in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );

  // Stage side: the register itself.
  modport slave (
    input  flush, in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake. SKID=1 builds a
// two-entry skid stage whose in_ready is registered (no combinational
// path from out_ready); SKID=0 builds a single-entry stage with a
// combinational in_ready. Bubbles carry an all-zero control bundle.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1
) (
  input logic             clk,
  input logic             clr,
  pipe_stage_reg_if.slave bus
);

  // State value doubles as the held-entry count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_in_ready;
  logic [DATA_W-1:0] r_h_data;
  logic [CTRL_W-1:0] r_h_ctrl;
  logic [DATA_W-1:0] r_s_data;
  logic [CTRL_W-1:0] r_s_ctrl;
  logic [15:0]       r_stall_cnt;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_pop;
  logic w_stall;
  logic w_load_h;
  logic w_h_from_s;
  logic w_load_s;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_out_valid = (r_state != EMPTY);
  // Single-entry stage may refill in the same cycle it drains.
  assign w_in_ready  = (SKID != 0) ? r_in_ready
                                   : (clr & (~w_out_valid | bus.out_ready));
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_stall     = w_out_valid & ~bus.out_ready;

  // Next-state and register-load selection; flush overrides any transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_load_h    = 1'b0;
    w_h_from_s  = 1'b0;
    w_load_s    = 1'b0;
    if (bus.flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_load_h    = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_load_h = 1'b1;
          end else if (w_accept && (SKID != 0)) begin
            w_state_nxt = TWO;
            w_load_s    = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (w_pop) begin
            w_state_nxt = ONE;
            w_h_from_s  = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Control state: occupancy, registered ready and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != TWO);
      if (w_stall) begin
        r_stall_cnt <= sat_inc16(r_stall_cnt);
      end
    end
  end

  // Payload registers: head H and skid S; hold value when not loaded.
  always_ff @(posedge clk) begin
    if (!clr) begin
      r_h_data <= '0;
      r_h_ctrl <= '0;
      r_s_data <= '0;
      r_s_ctrl <= '0;
    end else begin
      if (w_load_h) begin
        r_h_data <= bus.in_data;
        r_h_ctrl <= bus.in_ctrl;
      end else if (w_h_from_s) begin
        r_h_data <= r_s_data;
        r_h_ctrl <= r_s_ctrl;
      end
      if (w_load_s) begin
        r_s_data <= bus.in_data;
        r_s_ctrl <= bus.in_ctrl;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_h_data;
  assign bus.out_ctrl  = w_out_valid ? r_h_ctrl : '0;
  assign bus.occupancy = r_state;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the payload width (e.g. concatenated PC/result/busB).
REQ-002 The block SHALL have parameter CTRL_W, default 12, the control-bundle width (MemWr, RegWr, MemtoReg, Branch, ...).
REQ-003 The block SHALL have parameter SKID, default 1: 1 = two-entry skid stage, 0 = single-entry stage.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-005 The block SHALL have port clr, input, 1, reset: synchronous, active-low.
REQ-006 The block SHALL have port flush, input, 1, synchronous kill of all held and incoming entries.
REQ-007 The block SHALL have port in_valid, input, 1, upstream entry present.
REQ-008 The block SHALL have port in_ready, output, 1, stage can accept; transfer occurs when in_valid & in_ready at posedge.
REQ-009 The block SHALL have ports in_data (input, DATA_W) and in_ctrl (input, CTRL_W), the upstream payload and controls.
REQ-010 The block SHALL have port out_valid, output, 1, head entry present.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts; transfer occurs when out_valid & out_ready at posedge.
REQ-012 The block SHALL have ports out_data (output, DATA_W) and out_ctrl (output, CTRL_W), the head entry.
REQ-013 The block SHALL have port occupancy, output, 2, number of held entries (0..2).
REQ-014 The block SHALL have port stall_cnt, output, 16, cycles with out_valid=1 and out_ready=0.

Function
REQ-015 Priority at each posedge SHALL be: clr low > flush > normal transfer.
REQ-016 Entries SHALL leave in arrival order; an entry accepted at edge N SHALL be visible on out_* immediately after edge N (latency 1).
REQ-017 The SKID=1 states SHALL be EMPTY (occ 0), ONE (occ 1), TWO (occ 2), with head register H and skid register S.
REQ-018 SKID=1, EMPTY: accept -> ONE, H<=input.
REQ-019 SKID=1, ONE: accept only -> TWO, S<=input; pop only -> EMPTY; accept+pop -> ONE, H<=input; neither -> ONE.
REQ-020 SKID=1, TWO: pop -> ONE, H<=S; no accept possible.
REQ-021 SKID=1: in_ready SHALL be registered, equal to (next state != TWO), with no combinational path from out_ready.
REQ-022 SKID=0: a single register SHALL be used; in_ready = !out_valid | out_ready (combinational); states EMPTY/ONE only.
REQ-023 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble), so legacy consumers that ignore valid see no writes.
REQ-024 out_data SHALL hold its last value when no load occurs (no toggling on bubbles); it is don't-care when out_valid=0.
REQ-025 flush=1 at posedge SHALL make next state EMPTY, out_valid 0, out_ctrl 0; an input presented with in_valid&in_ready that cycle SHALL be discarded.
REQ-026 After flush, in_ready SHALL be 1 (SKID=1: on the next cycle; SKID=0: immediately).
REQ-027 stall_cnt SHALL increment by 1 per posedge with out_valid=1 & out_ready=0, saturate at 0xFFFF, and be unaffected by flush.
REQ-028 in_valid/in_data SHALL be ignored when in_ready=0; upstream holding data stable is not required for correctness.
REQ-029 occupancy SHALL equal the current state count (registered).

Reset
REQ-030 With clr=0 at posedge: state EMPTY, out_valid 0, out_ctrl 0, out_data 0, occupancy 0, stall_cnt 0.
REQ-031 in_ready SHALL be 0 while clr=0 and 1 from the first posedge with clr=1 (SKID=1), or immediately when clr=1 (SKID=0).
REQ-032 Reset asserted mid-operation (state TWO, stall_cnt nonzero) SHALL discard both entries and clear all counters in one edge.

Verification
REQ-033 Streaming: SKID=1, out_ready=1, push D=0x10..0x17 back-to-back -> out_data 0x10..0x17 in order, one per cycle, 1-cycle latency, occupancy stays 1.
REQ-034 Backpressure: push 0xA1,0xA2,0xA3 with out_ready=0 -> occupancy 2, in_ready=0, 0xA3 not accepted; release out_ready -> 0xA1 then 0xA2; stall_cnt = stalled cycles.
REQ-035 Flush: state TWO with ctrl=0xFFF, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0x000, occupancy 0; flushed input never appears.
REQ-036 Saturation: hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=0xFFFF and stays there.
REQ-037 Reset mid-run: state TWO, stall_cnt=5, clr=0 one edge -> all outputs reset per REQ-030; after release, push 0x55 -> out 0x55 next cycle.
REQ-038 SKID=0: out_ready=0 with entry held -> in_ready=0; out_ready=1 same cycle as in_valid -> simultaneous pop+load, no bubble.
